// File: rtl/qqspi_rcache.sv
// Direct-mapped write-through read cache in front of qqspi; read hit 1 cycle, miss/write 1 + qqspi latency.
// Backpressure: requests stall (no cpu_ready) while filling, writing, draining or flushing.
module qqspi_rcache #(
    parameter int LINES      = 64,
    parameter int INDEX_BITS = 6
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cpu_valid_i,
    input  logic [22:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic [3:0]  cpu_wstrb_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_ready_o,
    input  logic        invalidate_i,
    output logic        busy_o,
    output logic        mem_valid_o,
    output logic [22:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    localparam int TAG_W = 23 - INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_LINE = INDEX_BITS'(LINES - 1);

    typedef enum logic [1:0] {IDLE, MEM_REQ, DRAIN, FLUSH} state_t;

    state_t                  state_q, state_d;
    logic                    cpu_ready_q, cpu_ready_d;
    logic [31:0]             cpu_rdata_q, cpu_rdata_d;
    logic                    mem_valid_q, mem_valid_d;
    logic [22:0]             mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic [3:0]              mem_wstrb_q, mem_wstrb_d;
    logic                    busy_q, busy_d;
    logic                    flush_pend_q, flush_pend_d;
    logic [INDEX_BITS-1:0]   cnt_q, cnt_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q [LINES];
    logic [31:0]             data_q [LINES];

    logic [INDEX_BITS-1:0]   cpu_idx, mem_idx;
    logic [TAG_W-1:0]        cpu_tag, mem_tag;
    logic                    hit, is_write, accept;
    logic                    fill_we, merge_we;

    assign cpu_idx  = cpu_addr_i[INDEX_BITS-1:0];
    assign cpu_tag  = cpu_addr_i[22:INDEX_BITS];
    assign mem_idx  = mem_addr_q[INDEX_BITS-1:0];
    assign mem_tag  = mem_addr_q[22:INDEX_BITS];
    assign hit      = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign is_write = |cpu_wstrb_i;
    // A request that needs qqspi is held off while a previous ready is still high.
    assign accept   = cpu_valid_i && !cpu_ready_q && !((is_write || !hit) && mem_ready_i);

    always_comb begin
        state_d      = state_q;
        cpu_ready_d  = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        flush_pend_d = flush_pend_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        fill_we      = 1'b0;
        merge_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_write && hit) begin
                        cpu_ready_d = 1'b1;
                        cpu_rdata_d = data_q[cpu_idx];
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_addr_d  = cpu_addr_i;
                        mem_wdata_d = cpu_wdata_i;
                        mem_wstrb_d = cpu_wstrb_i;
                        merge_we    = is_write && hit;
                        state_d     = MEM_REQ;
                    end
                    if (invalidate_i) flush_pend_d = 1'b1;
                end else if (invalidate_i || flush_pend_q) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            MEM_REQ: begin
                if (invalidate_i) flush_pend_d = 1'b1;
                if (mem_ready_i) begin
                    mem_valid_d = 1'b0;
                    cpu_ready_d = 1'b1;
                    state_d     = DRAIN;
                    if (mem_wstrb_q == 4'b0000) begin
                        cpu_rdata_d      = mem_rdata_i;
                        fill_we          = 1'b1;
                        valid_d[mem_idx] = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (invalidate_i) flush_pend_d = 1'b1;
                if (!mem_ready_i) begin
                    if (flush_pend_q || invalidate_i) begin
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                valid_d[cnt_q] = 1'b0;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == LAST_LINE) begin
                    state_d      = IDLE;
                    flush_pend_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || flush_pend_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cpu_ready_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            busy_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_rdata_q  <= cpu_rdata_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            busy_q       <= busy_d;
            flush_pend_q <= flush_pend_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
        end
    end

    // Line storage needs no reset; valid bits guard it. Writes are dropped under reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (fill_we) begin
                data_q[mem_idx] <= mem_rdata_i;
                tag_q[mem_idx]  <= mem_tag;
            end else if (merge_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (cpu_wstrb_i[i]) data_q[cpu_idx][8*i +: 8] <= cpu_wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign cpu_ready_o = cpu_ready_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign mem_valid_o = mem_valid_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wstrb_o = mem_wstrb_q;
    assign busy_o      = busy_q;

endmodule
